// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter for the VGA adapter pixel-write port, with a full-screen clear sweep.
// state  | meaning
// IDLE   | requesters arbitrated round-robin, one pixel per cycle
// CLEAR  | sweep writes every on-screen dot with the latched colour
module vga_plot_arbiter #(
    parameter int BITS_PER_COLOUR_CHANNEL = 3,
    parameter     RESOLUTION              = "320x240",
    localparam int CW    = 3 * BITS_PER_COLOUR_CHANNEL,
    localparam int XW    = (RESOLUTION == "160x120") ? 8 : 9,
    localparam int YW    = (RESOLUTION == "160x120") ? 7 : 8,
    localparam int X_MAX = (RESOLUTION == "160x120") ? 160 : 320,
    localparam int Y_MAX = (RESOLUTION == "160x120") ? 120 : 240
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear_start,
    input  logic [CW-1:0] clear_colour,
    output logic          clear_busy,
    output logic          clear_done,
    input  logic          r0_valid,
    input  logic [XW-1:0] r0_x,
    input  logic [YW-1:0] r0_y,
    input  logic [CW-1:0] r0_colour,
    output logic          r0_ready,
    input  logic          r1_valid,
    input  logic [XW-1:0] r1_x,
    input  logic [YW-1:0] r1_y,
    input  logic [CW-1:0] r1_colour,
    output logic          r1_ready,
    input  logic          r2_valid,
    input  logic [XW-1:0] r2_x,
    input  logic [YW-1:0] r2_y,
    input  logic [CW-1:0] r2_colour,
    output logic          r2_ready,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] colour,
    output logic          plot
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    localparam logic [XW-1:0] X_LIM  = XW'(X_MAX);
    localparam logic [YW-1:0] Y_LIM  = YW'(Y_MAX);
    localparam logic [XW-1:0] X_LAST = XW'(X_MAX - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_MAX - 1);

    logic [0:0]    r_state;
    logic [1:0]    r_ptr;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [CW-1:0] r_colour;
    logic          r_plot;
    logic          r_done;
    logic [XW-1:0] r_cx;
    logic [YW-1:0] r_cy;
    logic [CW-1:0] r_clr;

    logic [2:0]    w_valid;
    logic [1:0]    w_ptr1;
    logic [1:0]    w_ptr2;
    logic          w_any;
    logic [1:0]    w_sel;
    logic [1:0]    w_next_ptr;
    logic [2:0]    w_grant;
    logic [XW-1:0] w_sel_x;
    logic [YW-1:0] w_sel_y;
    logic [CW-1:0] w_sel_c;
    logic          w_in_range;

    assign w_valid = {r2_valid, r1_valid, r0_valid};

    // Search order ptr, ptr+1, ptr+2 (mod 3); no grants at all during a sweep.
    always_comb begin
        w_ptr1 = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
        w_ptr2 = (r_ptr == 2'd0) ? 2'd2 : r_ptr - 2'd1;
        w_any  = 1'b0;
        w_sel  = r_ptr;
        if (r_state == S_IDLE) begin
            if (w_valid[r_ptr]) begin
                w_any = 1'b1;
                w_sel = r_ptr;
            end else if (w_valid[w_ptr1]) begin
                w_any = 1'b1;
                w_sel = w_ptr1;
            end else if (w_valid[w_ptr2]) begin
                w_any = 1'b1;
                w_sel = w_ptr2;
            end
        end
        w_grant    = w_any ? (3'b001 << w_sel) : 3'b000;
        w_next_ptr = (w_sel == 2'd2) ? 2'd0 : w_sel + 2'd1;
    end

    always_comb begin
        case (w_sel)
            2'd1:    begin w_sel_x = r1_x; w_sel_y = r1_y; w_sel_c = r1_colour; end
            2'd2:    begin w_sel_x = r2_x; w_sel_y = r2_y; w_sel_c = r2_colour; end
            default: begin w_sel_x = r0_x; w_sel_y = r0_y; w_sel_c = r0_colour; end
        endcase
        w_in_range = (w_sel_x < X_LIM) && (w_sel_y < Y_LIM);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ptr    <= 2'd0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_done   <= 1'b0;
            r_cx     <= '0;
            r_cy     <= '0;
            r_clr    <= '0;
        end else begin
            r_plot <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_ptr <= w_next_ptr;
                        // Off-screen pixels are consumed but never written.
                        if (w_in_range) begin
                            r_x      <= w_sel_x;
                            r_y      <= w_sel_y;
                            r_colour <= w_sel_c;
                            r_plot   <= 1'b1;
                        end
                    end
                    if (clear_start) begin
                        r_clr   <= clear_colour;
                        r_cx    <= '0;
                        r_cy    <= '0;
                        r_state <= S_CLEAR;
                    end
                end
                default: begin
                    r_x      <= r_cx;
                    r_y      <= r_cy;
                    r_colour <= r_clr;
                    r_plot   <= 1'b1;
                    if (r_cx == X_LAST) begin
                        r_cx <= '0;
                        if (r_cy == Y_LAST) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_cy <= r_cy + 1'b1;
                        end
                    end else begin
                        r_cx <= r_cx + 1'b1;
                    end
                end
            endcase
        end
    end

    assign r0_ready   = w_grant[0];
    assign r1_ready   = w_grant[1];
    assign r2_ready   = w_grant[2];
    assign x          = r_x;
    assign y          = r_y;
    assign colour     = r_colour;
    assign plot       = r_plot;
    assign clear_busy = (r_state == S_CLEAR);
    assign clear_done = r_done;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: a 320x240 and a 160x120 instance run side by side
// against a flat pixel-index model, plus directed literal checks.
module tb_vga_plot_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst      [2];
    logic       cs       [2];
    logic [8:0] ccol_in  [2];
    logic [2:0] v        [2];
    logic [8:0] ix       [2][3];
    logic [7:0] iy       [2][3];
    logic [8:0] ic       [2][3];

    logic [2:0] b_rdy, s_rdy;
    logic [8:0] b_x, b_c, s_c;
    logic [7:0] b_y, s_x;
    logic [6:0] s_y;
    logic       b_plot, s_plot, b_busy, s_busy, b_done, s_done;

    logic [2:0] o_rdy  [2];
    logic [8:0] o_x    [2];
    logic [7:0] o_y    [2];
    logic [8:0] o_c    [2];
    logic       o_plot [2];
    logic       o_busy [2];
    logic       o_done [2];

    assign o_rdy[0] = b_rdy;  assign o_rdy[1] = s_rdy;
    assign o_x[0] = b_x;      assign o_x[1] = {1'b0, s_x};
    assign o_y[0] = b_y;      assign o_y[1] = {1'b0, s_y};
    assign o_c[0] = b_c;      assign o_c[1] = s_c;
    assign o_plot[0] = b_plot; assign o_plot[1] = s_plot;
    assign o_busy[0] = b_busy; assign o_busy[1] = s_busy;
    assign o_done[0] = b_done; assign o_done[1] = s_done;

    vga_plot_arbiter #(.BITS_PER_COLOUR_CHANNEL(3), .RESOLUTION("320x240")) u_big (
        .clock(clk), .reset(rst[0]), .clear_start(cs[0]), .clear_colour(ccol_in[0]),
        .clear_busy(b_busy), .clear_done(b_done),
        .r0_valid(v[0][0]), .r0_x(ix[0][0]), .r0_y(iy[0][0]), .r0_colour(ic[0][0]), .r0_ready(b_rdy[0]),
        .r1_valid(v[0][1]), .r1_x(ix[0][1]), .r1_y(iy[0][1]), .r1_colour(ic[0][1]), .r1_ready(b_rdy[1]),
        .r2_valid(v[0][2]), .r2_x(ix[0][2]), .r2_y(iy[0][2]), .r2_colour(ic[0][2]), .r2_ready(b_rdy[2]),
        .x(b_x), .y(b_y), .colour(b_c), .plot(b_plot)
    );

    vga_plot_arbiter #(.BITS_PER_COLOUR_CHANNEL(3), .RESOLUTION("160x120")) u_small (
        .clock(clk), .reset(rst[1]), .clear_start(cs[1]), .clear_colour(ccol_in[1]),
        .clear_busy(s_busy), .clear_done(s_done),
        .r0_valid(v[1][0]), .r0_x(ix[1][0][7:0]), .r0_y(iy[1][0][6:0]), .r0_colour(ic[1][0]), .r0_ready(s_rdy[0]),
        .r1_valid(v[1][1]), .r1_x(ix[1][1][7:0]), .r1_y(iy[1][1][6:0]), .r1_colour(ic[1][1]), .r1_ready(s_rdy[1]),
        .r2_valid(v[1][2]), .r2_x(ix[1][2][7:0]), .r2_y(iy[1][2][6:0]), .r2_colour(ic[1][2]), .r2_ready(s_rdy[2]),
        .x(s_x), .y(s_y), .colour(s_c), .plot(s_plot)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at t=%0t", name, d, act, exp, $time);
        end
    endtask

    // Model: the sweep is a flat pixel index p with x = p % XM, y = p / XM.
    int         XM [2] = '{320, 160};
    int         YM [2] = '{240, 120};
    int         m_mode [2] = '{0, 0};
    int         m_ptr  [2] = '{0, 0};
    int         m_p    [2] = '{0, 0};
    logic [8:0] m_ccol [2] = '{9'h0, 9'h0};
    logic [8:0] m_x    [2] = '{9'h0, 9'h0};
    logic [7:0] m_y    [2] = '{8'h0, 8'h0};
    logic [8:0] m_c    [2] = '{9'h0, 9'h0};
    logic       m_plot [2] = '{1'b0, 1'b0};
    logic       m_done [2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int g;
            if (rst[d]) begin
                m_mode[d] = 0; m_ptr[d] = 0; m_p[d] = 0;
                m_x[d] = '0; m_y[d] = '0; m_c[d] = '0;
                m_plot[d] = 1'b0; m_done[d] = 1'b0;
            end
            g = -1;
            if (m_mode[d] == 0 && !rst[d])
                for (int i = 2; i >= 0; i--)
                    if (v[d][(m_ptr[d] + i) % 3]) g = (m_ptr[d] + i) % 3;
            for (int k = 0; k < 3; k++)
                chk($sformatf("ready%0d", k), d, 32'(o_rdy[d][k]), 32'(g == k));
            chk("plot", d, 32'(o_plot[d]), 32'(m_plot[d]));
            chk("clear_done", d, 32'(o_done[d]), 32'(m_done[d]));
            chk("clear_busy", d, 32'(o_busy[d]), 32'(m_mode[d]));
            if (m_plot[d] || rst[d]) begin
                chk("x", d, 32'(o_x[d]), 32'(m_x[d]));
                chk("y", d, 32'(o_y[d]), 32'(m_y[d]));
                chk("colour", d, 32'(o_c[d]), 32'(m_c[d]));
            end
            if (!rst[d]) begin
                if (m_mode[d] == 0) begin
                    m_done[d] = 1'b0;
                    m_plot[d] = 1'b0;
                    if (g >= 0) begin
                        m_ptr[d] = (g + 1) % 3;
                        if (int'(ix[d][g]) < XM[d] && int'(iy[d][g]) < YM[d]) begin
                            m_x[d] = ix[d][g]; m_y[d] = iy[d][g]; m_c[d] = ic[d][g];
                            m_plot[d] = 1'b1;
                        end
                    end
                    if (cs[d]) begin
                        m_mode[d] = 1; m_ccol[d] = ccol_in[d]; m_p[d] = 0;
                    end
                end else begin
                    m_x[d] = 9'(m_p[d] % XM[d]);
                    m_y[d] = 8'(m_p[d] / XM[d]);
                    m_c[d] = m_ccol[d];
                    m_plot[d] = 1'b1;
                    m_p[d]++;
                    m_done[d] = (m_p[d] == XM[d] * YM[d]);
                    if (m_done[d]) m_mode[d] = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic big_seq();
        int n;
        logic got;
        // single requester r1
        v[0] = 3'b010; ix[0][1] = 9'd5; iy[0][1] = 8'd7; ic[0][1] = 9'h1C0;
        @(negedge clk); chk("r1_ready", 0, 32'(b_rdy), 32'h2);
        tick(); v[0] = 3'b000;
        @(negedge clk);
        chk("r1_plot", 0, 32'(b_plot), 32'h1);
        chk("r1_x", 0, 32'(b_x), 32'd5);
        chk("r1_y", 0, 32'(b_y), 32'd7);
        chk("r1_colour", 0, 32'(b_c), 32'h1C0);
        tick(); @(negedge clk); chk("r1_plot_off", 0, 32'(b_plot), 32'h0);
        // all three from reset
        tick(); rst[0] = 1'b1; tick(); rst[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ix[0][k] = 9'(10 + k); iy[0][k] = 8'(20 + k); ic[0][k] = 9'(k + 1);
        end
        v[0] = 3'b111;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_grant", 0, 32'(b_rdy), 32'(1 << (i % 3)));
            if (i > 0) begin
                chk("rr_plot", 0, 32'(b_plot), 32'h1);
                chk("rr_x", 0, 32'(b_x), 32'(10 + (i - 1) % 3));
            end
            tick();
        end
        v[0] = 3'b000;
        @(negedge clk);
        chk("rr_plot6", 0, 32'(b_plot), 32'h1);
        chk("rr_x6", 0, 32'(b_x), 32'd12);
        // out-of-range from r2 with ptr at 2
        tick(); v[0] = 3'b010;
        @(negedge clk); tick();
        v[0] = 3'b100; ix[0][2] = 9'd320; iy[0][2] = 8'd10;
        @(negedge clk); chk("oor_ready", 0, 32'(b_rdy), 32'h4);
        tick(); v[0] = 3'b111; ix[0][2] = 9'd12;
        @(negedge clk);
        chk("oor_plot", 0, 32'(b_plot), 32'h0);
        chk("oor_ptr", 0, 32'(b_rdy), 32'h1);
        tick(); v[0] = 3'b000;
        // clear while r0 is requesting
        v[0] = 3'b001; ix[0][0] = 9'd1; iy[0][0] = 8'd2; ic[0][0] = 9'h003;
        cs[0] = 1'b1; ccol_in[0] = 9'h007;
        @(negedge clk); chk("clr_r0_ready", 0, 32'(b_rdy), 32'h1);
        tick(); cs[0] = 1'b0; ccol_in[0] = 9'h1FF;
        ix[0][0] = 9'd11; iy[0][0] = 8'd12; ic[0][0] = 9'h055;
        @(negedge clk);
        chk("clr_r0_plot", 0, 32'(b_plot), 32'h1);
        chk("clr_r0_x", 0, 32'(b_x), 32'd1);
        chk("clr_busy", 0, 32'(b_busy), 32'h1);
        n = 0; got = 1'b0;
        for (int i = 0; i < 80000 && !got; i++) begin
            @(negedge clk);
            if (b_plot && b_c == 9'h007) n++;
            if (b_done) got = 1'b1;
        end
        chk("clr_done_seen", 0, 32'(got), 32'h1);
        chk("clr_plot_count", 0, 32'(n), 32'd76800);
        chk("clr_last_x", 0, 32'(b_x), 32'd319);
        chk("clr_last_y", 0, 32'(b_y), 32'd239);
        chk("clr_resume_ready", 0, 32'(b_rdy), 32'h1);
        chk("clr_busy_end", 0, 32'(b_busy), 32'h0);
        tick(); v[0] = 3'b000;
        @(negedge clk);
        chk("post_r0_plot", 0, 32'(b_plot), 32'h1);
        chk("post_r0_x", 0, 32'(b_x), 32'd11);
        chk("post_r0_y", 0, 32'(b_y), 32'd12);
        chk("post_r0_colour", 0, 32'(b_c), 32'h055);
    endtask

    task automatic small_seq();
        int n, dn, pulse;
        tick(); cs[1] = 1'b1; ccol_in[1] = 9'h1AA;
        tick(); cs[1] = 1'b0;
        n = 0;
        for (int i = 0; i < 1000 && n < 500; i++) begin
            @(negedge clk);
            if (s_plot) n++;
        end
        chk("abort_reached", 1, 32'(n), 32'd500);
        tick(); rst[1] = 1'b1;
        @(negedge clk);
        chk("abort_plot", 1, 32'(s_plot), 32'h0);
        chk("abort_x", 1, 32'(s_x), 32'h0);
        chk("abort_y", 1, 32'(s_y), 32'h0);
        chk("abort_colour", 1, 32'(s_c), 32'h0);
        chk("abort_busy", 1, 32'(s_busy), 32'h0);
        chk("abort_done", 1, 32'(s_done), 32'h0);
        tick(); rst[1] = 1'b0;
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_done || s_plot) dn++;
        end
        chk("abort_quiet", 1, 32'(dn), 32'h0);
        tick(); cs[1] = 1'b1; ccol_in[1] = 9'h0F0;
        tick(); cs[1] = 1'b0; ccol_in[1] = 9'h1FF;
        n = 0; dn = 0; pulse = 0;
        for (int i = 0; i < 19300; i++) begin
            @(negedge clk);
            if (s_plot && s_c == 9'h0F0) n++;
            if (s_done) dn++;
            if (n == 5000 && pulse == 0) begin
                @(posedge clk); #2; cs[1] = 1'b1; pulse = 1;
            end else if (pulse == 1) begin
                @(posedge clk); #2; cs[1] = 1'b0; pulse = 2;
            end
        end
        chk("fresh_plot_count", 1, 32'(n), 32'd19200);
        chk("fresh_done_count", 1, 32'(dn), 32'd1);
        chk("fresh_busy_end", 1, 32'(s_busy), 32'h0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; cs[d] = 1'b0; ccol_in[d] = '0; v[d] = '0;
            for (int k = 0; k < 3; k++) begin
                ix[d][k] = '0; iy[d][k] = '0; ic[d][k] = '0;
            end
        end
        @(negedge clk);
        chk("reset_plot", 0, 32'(b_plot), 32'h0);
        chk("reset_x", 0, 32'(b_x), 32'h0);
        chk("reset_ready", 0, 32'(b_rdy), 32'h0);
        tick();
        rst[0] = 1'b0; rst[1] = 1'b0;
        fork
            big_seq();
            small_seq();
        join
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_plot_arbiter.md
# vga_plot_arbiter

Shares the single pixel-write port of the VGA adapter's video memory among three drawing requesters, and has a built-in screen-clear sequencer. Requesters use a valid/ready handshake; grants rotate round-robin. The registered x/y/colour/plot outputs drive the adapter write side directly. A clear sweep has priority over all requesters and writes every on-screen dot with one colour.

## Interface
Parameters:
- BITS_PER_COLOUR_CHANNEL, 3: bits per R/G/B channel. CW = 3*BITS_PER_COLOUR_CHANNEL.
- RESOLUTION, "320x240": either "320x240" or "160x120".
  - "320x240": XW=9, YW=8, X_MAX=320, Y_MAX=240.
  - "160x120": XW=8, YW=7, X_MAX=160, Y_MAX=120.

Ports:
- clock  in  1  single clock for the block.
- reset  in  1  asynchronous, active-high reset.
- clear_start  in  1  request a full-screen clear; sampled in IDLE only.
- clear_colour  in  CW  fill colour; latched on an accepted clear_start.
- clear_busy  out  1  high while in state CLEAR.
- clear_done  out  1  one-cycle pulse, coincident with the last clear plot.
- rK_valid, K=0..2  in  1  requester K has a pixel to write.
- rK_x, K=0..2  in  XW  pixel column.
- rK_y, K=0..2  in  YW  pixel row.
- rK_colour, K=0..2  in  CW  pixel colour.
- rK_ready, K=0..2  out  1  combinational grant; a transfer occurs when rK_valid && rK_ready.
- x  out  XW  registered write column.
- y  out  YW  registered write row.
- colour  out  CW  registered write colour.
- plot  out  1  registered write enable to video memory.

## Operation
- States: IDLE and CLEAR.
- Reset values: state=IDLE, ptr=0, x=0, y=0, colour=0, plot=0, clear_busy=0, clear_done=0, all rK_ready=0.
- IDLE arbitration:
  - Search order is ptr, ptr+1, ptr+2 (mod 3). The first requester with valid high gets ready=1; all others get ready=0.
  - At most one ready is high in any cycle.
  - After a grant to K, ptr <= (K+1) mod 3. With no valid requester, ptr holds.
- Requesters hold valid and data stable until ready. An accepted pixel appears on x/y/colour with plot=1 on the next cycle.
- Out-of-range pixels (rK_x >= X_MAX or rK_y >= Y_MAX) are accepted (ready=1) and dropped: plot=0 that next cycle. ptr still advances.
- With no transfer in a cycle, plot=0 next cycle. x/y/colour hold their last values.
- clear_start in IDLE:
  - Latch clear_colour, set the sweep counters cx=0, cy=0, go to CLEAR.
  - A requester granted in that same cycle still completes its transfer.
- CLEAR:
  - All rK_ready=0.
  - Each cycle, register x=cx, y=cy, colour=latched colour, plot=1.
  - cx increments; at X_MAX-1 it wraps to 0 and cy increments.
  - At (X_MAX-1, Y_MAX-1): register the final plot, set clear_done=1 for one cycle, return to IDLE.
- clear_start while in CLEAR is ignored. It is not queued.
- Reset mid-clear aborts the sweep: IDLE, no clear_done pulse, plot=0.

## Timing
- Requester path latency: a handshake at clock edge n gives plot/x/y/colour valid after edge n+1.
- rK_ready depends combinationally on state, ptr and all valids. It does not depend on x, y or colour.
- clear_busy = (state==CLEAR), registered. It rises the cycle after clear_start is accepted.
- Clear sweep timing:
  - The first clear plot (0,0) is visible one cycle after clear_busy rises.
  - There are X_MAX*Y_MAX consecutive plot cycles with no gaps: 76800 at 320x240, 19200 at 160x120.
  - clear_done and the last plot (X_MAX-1, Y_MAX-1) are high in the same cycle. In that cycle clear_busy=0 and arbitration resumes.
- Sustained throughput is one pixel per cycle total, shared round-robin.

## Test plan
- Reset, then r1 only: valid with x=5, y=7, colour=9'h1C0. Required: r1_ready=1 that cycle; next cycle plot=1, x=5, y=7, colour=1C0; then plot=0.
- All three valid continuously for 6 cycles from reset. Required: grant order r0,r1,r2,r0,r1,r2, exactly one ready per cycle, six consecutive plots.
- r2 valid with x=320, y=10 (320x240). Required: r2_ready=1, next cycle plot=0, ptr advances to 0.
- clear_start with clear_colour=9'h007 while r0 is valid. Required:
  - r0's transfer completes first.
  - 76800 consecutive plots with colour 007, rows sweeping 0..239 and columns 0..319.
  - r0_ready=0 throughout.
  - clear_done with (319,239), then r0 is served.
- At 160x120, assert reset at clear pixel 500. Required: all outputs at reset values immediately, no clear_done. A fresh clear_start gives a full 19200-plot sweep.
- Pulse clear_start again mid-clear. Required: ignored; the sweep completes exactly once with a single clear_done pulse.
